// File: rtl/tempsense_sar_ctrl.sv
// SAR conversion sequencer for the tempsense delay-line core: precharge/discharge/measure
// per bit, MSB first, with single-shot and continuous modes.
module tempsense_sar_ctrl #(
  parameter int N_VDAC   = 6,
  parameter int MEAS_CYC = 2,
  parameter int GAP_CYC  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic              i_tempdelay,
  output logic [N_VDAC-1:0] o_dac_data,
  output logic              o_dac_en,
  output logic              o_precharge_n,
  output logic [N_VDAC-1:0] o_result,
  output logic              o_valid,
  output logic              o_clip,
  output logic              o_busy
);

  localparam int CMAX = (MEAS_CYC > GAP_CYC) ? MEAS_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRECHARGE, S_DISCHARGE, S_MEASURE, S_SAMPLE, S_DONE, S_WAIT
  } state_t;

  state_t            state, state_nx;
  logic [N_VDAC-1:0] trial;
  logic [N_VDAC-1:0] bit_mask;
  logic [BW-1:0]     bit_idx;
  logic [CW-1:0]     cnt;
  logic [1:0]        td_sync;
  logic [N_VDAC-1:0] result;
  logic              clip;
  logic              valid;

  assign bit_mask = N_VDAC'(1) << bit_idx;

  always_comb begin
    state_nx      = state;
    o_dac_data    = '1;
    o_precharge_n = 1'b0;
    o_dac_en      = 1'b1;
    o_busy        = 1'b1;
    case (state)
      S_IDLE: begin
        o_dac_en = 1'b0;
        o_busy   = 1'b0;
        if (i_start || i_continuous) state_nx = S_PRECHARGE;
      end
      S_PRECHARGE: state_nx = S_DISCHARGE;
      S_DISCHARGE: begin
        o_dac_data    = '0;
        o_precharge_n = 1'b1;
        state_nx      = S_MEASURE;
      end
      S_MEASURE: begin
        o_dac_data    = trial | bit_mask;
        o_precharge_n = 1'b1;
        if (cnt == CW'(MEAS_CYC - 1)) state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        o_dac_data    = trial | bit_mask;
        o_precharge_n = 1'b1;
        state_nx      = (bit_idx == '0) ? S_DONE : S_PRECHARGE;
      end
      S_DONE: state_nx = i_continuous ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (cnt == CW'(GAP_CYC - 1)) state_nx = i_continuous ? S_PRECHARGE : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      trial   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      td_sync <= '0;
      result  <= '0;
      clip    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state   <= state_nx;
      td_sync <= {td_sync[0], i_tempdelay};
      valid   <= (state == S_DONE);
      // counter restarts on every state change; only MEASURE and WAIT look at it
      cnt     <= (state_nx == state) ? cnt + CW'(1) : '0;
      case (state)
        S_IDLE, S_WAIT: begin
          if (state_nx == S_PRECHARGE) begin
            trial   <= '0;
            bit_idx <= BW'(N_VDAC - 1);
          end
        end
        S_SAMPLE: begin
          trial[bit_idx] <= td_sync[1];
          if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
        end
        S_DONE: begin
          result <= trial;
          clip   <= (trial == '0) || (trial == '1);
        end
        default: ;
      endcase
    end
  end

  assign o_result = result;
  assign o_clip   = clip;
  assign o_valid  = valid;

endmodule
